// File: rtl/multi_timer_pkg.sv
// Shared register offsets, CTRL bit positions and byte-lane merge helper for multi_timer.
// The DUTY register and PWM outputs exist only when TIMER_PWM_EN is defined.
package multi_timer_pkg;

    typedef enum logic [2:0] {
        TMR_CTRL   = 3'd0,
        TMR_STOP   = 3'd1,
        TMR_COUNT  = 3'd2,
        TMR_STATUS = 3'd3,
        TMR_DUTY   = 3'd4
    } tmr_reg_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQEN   = 2;
    localparam int CTRL_CLR     = 3;
    localparam int CTRL_PRE_LSB = 8;

    // Replace only the bytes whose lane enable is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = newVal[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: prescaler, counter with >= compare, W1C pending flag, IRQ mask.
// With TIMER_PWM_EN defined it also holds DUTY and drives a registered PWM output.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PRE_WIDTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [2:0]  reg_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
`ifdef TIMER_PWM_EN
    ,
    output logic        pwm_o
`endif
);

    logic                 en_q, en_d, oneshot_q, oneshot_d, irqEn_q, irqEn_d;
    logic                 pending_q, pending_d;
    logic [PRE_WIDTH-1:0] pre_q, pre_d, preCnt_q, preCnt_d;
    logic [WIDTH-1:0]     stop_q, stop_d, count_q, count_d;
    logic [31:0]          ctrlRd;
    logic                 wrCtrl, wrStop, wrCount, wrStatus, clrHit, w1cHit, tick, match;

    assign wrCtrl   = we_i && (reg_i == TMR_CTRL);
    assign wrStop   = we_i && (reg_i == TMR_STOP);
    assign wrCount  = we_i && (reg_i == TMR_COUNT);
    assign wrStatus = we_i && (reg_i == TMR_STATUS);
    assign clrHit   = wrCtrl && be_i[0] && wdata_i[CTRL_CLR];
    assign w1cHit   = wrStatus && be_i[0] && wdata_i[0];
    assign tick     = en_q && (preCnt_q == pre_q);
    assign match    = (count_q >= stop_q);
    assign irq_o    = pending_q && irqEn_q;

    always_comb begin
        ctrlRd                              = '0;
        ctrlRd[CTRL_EN]                     = en_q;
        ctrlRd[CTRL_ONESHOT]                = oneshot_q;
        ctrlRd[CTRL_IRQEN]                  = irqEn_q;
        ctrlRd[CTRL_PRE_LSB +: PRE_WIDTH]   = pre_q;
    end

    // Priority, lowest first: tick, bus writes, clr; pending set wins over W1C.
    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        irqEn_d   = irqEn_q;
        pre_d     = pre_q;
        stop_d    = stop_q;
        count_d   = count_q;
        preCnt_d  = preCnt_q;
        pending_d = pending_q;
        if (en_q) preCnt_d = tick ? '0 : preCnt_q + PRE_WIDTH'(1);
        if (tick) begin
            count_d = match ? '0 : count_q + WIDTH'(1);
            if (match && oneshot_q) en_d = 1'b0;
        end
        if (wrCtrl) begin
            pre_d = PRE_WIDTH'(byte_merge(ctrlRd, wdata_i, be_i) >> CTRL_PRE_LSB);
            if (be_i[0]) begin
                en_d      = wdata_i[CTRL_EN];
                oneshot_d = wdata_i[CTRL_ONESHOT];
                irqEn_d   = wdata_i[CTRL_IRQEN];
            end
        end
        if (wrStop)  stop_d  = WIDTH'(byte_merge(32'(stop_q), wdata_i, be_i));
        if (wrCount) count_d = WIDTH'(byte_merge(32'(count_q), wdata_i, be_i));
        if (clrHit) begin
            count_d  = '0;
            preCnt_d = '0;
        end
        if (w1cHit) pending_d = 1'b0;
        if (tick && match) pending_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            irqEn_q   <= 1'b0;
            pre_q     <= '0;
            stop_q    <= '1;
            count_q   <= '0;
            preCnt_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            irqEn_q   <= irqEn_d;
            pre_q     <= pre_d;
            stop_q    <= stop_d;
            count_q   <= count_d;
            preCnt_q  <= preCnt_d;
            pending_q <= pending_d;
        end
    end

`ifdef TIMER_PWM_EN
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        duty_d = duty_q;
        if (we_i && (reg_i == TMR_DUTY)) duty_d = WIDTH'(byte_merge(32'(duty_q), wdata_i, be_i));
        pwm_d = en_q && (count_q < duty_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
`endif

    always_comb begin
        rdata_o = '0;
        case (reg_i)
            TMR_CTRL:   rdata_o = ctrlRd;
            TMR_STOP:   rdata_o = 32'(stop_q);
            TMR_COUNT:  rdata_o = 32'(count_q);
            TMR_STATUS: rdata_o = {31'd0, pending_q};
`ifdef TIMER_PWM_EN
            TMR_DUTY:   rdata_o = 32'(duty_q);
`endif
            default:    rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/multi_timer.sv
// N-channel bus timer: address decode, read mux, interrupt OR and reset synchroniser.
// Defining TIMER_PWM_EN adds per-channel DUTY registers and the pwm_out port.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 32,
    parameter int PRE_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          resetq,
    input  logic                          select,
    input  logic [3:0]                    wr,
    input  logic [$clog2(CHANNELS)+2:0]   addr,
    input  logic [31:0]                   data_in,
    output logic [31:0]                   data_out,
    output logic                          interrupt
`ifdef TIMER_PWM_EN
    ,
    output logic [CHANNELS-1:0]           pwm_out
`endif
);

    logic [1:0]          rstSync_q;
    logic                rstN;
    logic [7:0]          chIdx;
    logic [31:0]         rdata [CHANNELS];
    logic [CHANNELS-1:0] irq;

    // Assert asynchronously, release two clocks after resetq rises.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) rstSync_q <= 2'b00;
        else         rstSync_q <= {rstSync_q[0], 1'b1};
    end

    assign rstN  = rstSync_q[1];
    assign chIdx = 8'(addr >> 3);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_channel #(
            .WIDTH     (WIDTH),
            .PRE_WIDTH (PRE_WIDTH)
        ) u_ch (
            .clk_i   (clk),
            .rst_ni  (rstN),
            .we_i    (select && (|wr) && (chIdx == 8'(i))),
            .reg_i   (addr[2:0]),
            .be_i    (wr),
            .wdata_i (data_in),
            .rdata_o (rdata[i]),
            .irq_o   (irq[i])
`ifdef TIMER_PWM_EN
            ,
            .pwm_o   (pwm_out[i])
`endif
        );
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chIdx == 8'(i)) data_out = rdata[i];
        end
    end

    assign interrupt = |irq;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer (3 channels) against a behavioural model.
// Covers the PWM feature as well when TIMER_PWM_EN is defined.
module tb_multi_timer;

    localparam int CH = 3;
    localparam int AW = $clog2(CH) + 3;

    logic          clk = 1'b0;
    logic          resetq = 1'b0;
    logic          select = 1'b0;
    logic [3:0]    wr = 4'h0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   data_in = '0;
    logic [31:0]   data_out;
    logic          interrupt;
`ifdef TIMER_PWM_EN
    logic [CH-1:0] pwm_out;
`endif

    int vecs = 0;
    int miss = 0;

    logic        mEn [CH], mOs [CH], mIe [CH], mPend [CH], mPwm [CH];
    logic [7:0]  mPre [CH], mPc [CH];
    logic [31:0] mStop [CH], mCount [CH], mDuty [CH];

    multi_timer #(.CHANNELS(CH), .WIDTH(32), .PRE_WIDTH(8)) dut (
        .clk       (clk),
        .resetq    (resetq),
        .select    (select),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .interrupt (interrupt)
`ifdef TIMER_PWM_EN
        ,
        .pwm_out   (pwm_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [AW-1:0] ad(input int c, input int r);
        return AW'(c * 8 + r);
    endfunction

    task automatic mdlReset();
        for (int c = 0; c < CH; c++) begin
            mEn[c] = 0; mOs[c] = 0; mIe[c] = 0; mPend[c] = 0; mPwm[c] = 0;
            mPre[c] = 0; mPc[c] = 0; mStop[c] = '1; mCount[c] = 0; mDuty[c] = 0;
        end
    endtask

    // One clock of the timer rules for every channel, given the bus cycle on that edge.
    task automatic mdlStep(input logic s, input logic [3:0] be, input logic [AW-1:0] a, input logic [31:0] d);
        int ch, r;
        ch = int'(a >> 3);
        r  = int'(a[2:0]);
        for (int c = 0; c < CH; c++) begin
            logic tk, fire, hit;
            logic [31:0] cnt;
            tk   = mEn[c] && (mPc[c] == mPre[c]);
            fire = tk && (mCount[c] >= mStop[c]);
            hit  = s && (be != 4'h0) && (ch == c);
            mPwm[c] = mEn[c] && (mCount[c] < mDuty[c]);
            cnt = mCount[c];
            if (tk) cnt = fire ? 32'd0 : mCount[c] + 32'd1;
            if (mEn[c]) mPc[c] = tk ? 8'd0 : mPc[c] + 8'd1;
            if (fire && mOs[c]) mEn[c] = 1'b0;
            if (hit) begin
                case (r)
                    0: begin
                        if (be[1]) mPre[c] = d[15:8];
                        if (be[0]) begin
                            mEn[c] = d[0]; mOs[c] = d[1]; mIe[c] = d[2];
                            if (d[3]) begin cnt = 0; mPc[c] = 0; end
                        end
                    end
                    1: mStop[c] = mrg(mStop[c], d, be);
                    2: cnt = mrg(mCount[c], d, be);
                    3: if (be[0] && d[0]) mPend[c] = 1'b0;
                    4: begin
`ifdef TIMER_PWM_EN
                        mDuty[c] = mrg(mDuty[c], d, be);
`endif
                    end
                    default: ;
                endcase
            end
            if (fire) mPend[c] = 1'b1;
            mCount[c] = cnt;
        end
    endtask

    function automatic logic [31:0] mdlRead(input logic [AW-1:0] a);
        int ch, r;
        ch = int'(a >> 3);
        r  = int'(a[2:0]);
        if (ch >= CH) return 32'd0;
        case (r)
            0: return {16'd0, mPre[ch], 5'd0, mIe[ch], mOs[ch], mEn[ch]};
            1: return mStop[ch];
            2: return mCount[ch];
            3: return {31'd0, mPend[ch]};
`ifdef TIMER_PWM_EN
            4: return mDuty[ch];
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic mdlIrq();
        logic v;
        v = 1'b0;
        for (int c = 0; c < CH; c++) v = v | (mPend[c] & mIe[c]);
        return v;
    endfunction

    function automatic logic [CH-1:0] mdlPwm();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = mPwm[c];
        return v;
    endfunction

    task automatic cycle(input logic s, input logic [3:0] be, input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        select = s; wr = be; addr = a; data_in = d;
        @(posedge clk);
        mdlStep(s, be, a, d);
        #1;
        select = 1'b0; wr = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 4'h0, '0, 32'd0);
    endtask

    task automatic wreg(input int c, input int r, input logic [31:0] d);
        cycle(1'b1, 4'hF, ad(c, r), d);
    endtask

    task automatic peek(input logic [AW-1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = data_out;
    endtask

    task automatic quiesce();
        for (int c = 0; c < CH; c++) begin
            wreg(c, 0, 32'h8);
            wreg(c, 3, 32'h1);
        end
    endtask

    task automatic releaseReset();
        @(negedge clk);
        resetq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] v, e;
        resetq = 1'b0;
        mdlReset();
        repeat (3) @(posedge clk);
        releaseReset();
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < 5; r++) begin
                peek(ad(c, r), v);
                e = (r == 1) ? 32'hFFFF_FFFF : 32'd0;
                vecs++;
                if (v !== e) begin
                    miss++;
                    $display("[TB] FAIL reset_reg ch%0d r%0d: got %h expected %h", c, r, v, e);
                end
            end
        end
        vecs++;
        if (interrupt !== 1'b0) begin
            miss++;
            $display("[TB] FAIL reset_irq: got %b expected 0", interrupt);
        end
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        int expCnt [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        quiesce();
        wreg(0, 1, 32'd3);
        wreg(0, 0, 32'h0000_000D);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) idle(1);
            peek(ad(0, 2), v);
            vecs++;
            if (v !== 32'(expCnt[k])) begin
                miss++;
                $display("[TB] FAIL periodic_count k%0d: got %0d expected %0d", k, v, expCnt[k]);
            end
            peek(ad(0, 3), v);
            vecs++;
            if (v !== 32'(k >= 4)) begin
                miss++;
                $display("[TB] FAIL periodic_pending k%0d: got %0d expected %0d", k, v, k >= 4);
            end
            vecs++;
            if (interrupt !== (k >= 4)) begin
                miss++;
                $display("[TB] FAIL periodic_irq k%0d: got %b expected %b", k, interrupt, k >= 4);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v, e;
        quiesce();
        wreg(1, 1, 32'd1);
        wreg(1, 0, 32'h0000_020B);
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            peek(ad(1, 3), v);
            vecs++;
            if (v !== 32'(k >= 6)) begin
                miss++;
                $display("[TB] FAIL oneshot_pending k%0d: got %0d expected %0d", k, v, k >= 6);
            end
            peek(ad(1, 2), v);
            e = (k >= 3 && k < 6) ? 32'd1 : 32'd0;
            vecs++;
            if (v !== e) begin
                miss++;
                $display("[TB] FAIL oneshot_count k%0d: got %0d expected %0d", k, v, e);
            end
        end
        peek(ad(1, 0), v);
        vecs++;
        if (v !== 32'h0000_0202) begin
            miss++;
            $display("[TB] FAIL oneshot_ctrl: got %h expected 00000202", v);
        end
        wreg(1, 3, 32'h1);
        idle(12);
        peek(ad(1, 3), v);
        vecs++;
        if (v !== 32'd0) begin
            miss++;
            $display("[TB] FAIL oneshot_rearm: got %0d expected 0", v);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] v;
        quiesce();
        wreg(2, 1, 32'd3);
        wreg(2, 0, 32'h0000_000D);
        idle(7);
        wreg(2, 3, 32'h1);
        peek(ad(2, 3), v);
        vecs++;
        if (v !== 32'd1 || interrupt !== 1'b1) begin
            miss++;
            $display("[TB] FAIL w1c_on_match: got pend %0d irq %b expected 1 1", v, interrupt);
        end
        wreg(2, 3, 32'h1);
        peek(ad(2, 3), v);
        vecs++;
        if (v !== 32'd0 || interrupt !== 1'b0) begin
            miss++;
            $display("[TB] FAIL w1c_clear: got pend %0d irq %b expected 0 0", v, interrupt);
        end
    endtask

    task automatic test_stop_below();
        logic [31:0] v;
        quiesce();
        wreg(2, 1, 32'hFFFF_FFFF);
        wreg(2, 0, 32'h9);
        idle(9);
        wreg(2, 0, 32'h0);
        peek(ad(2, 2), v);
        vecs++;
        if (v !== 32'd10) begin
            miss++;
            $display("[TB] FAIL stop_hold_count: got %0d expected 10", v);
        end
        wreg(2, 1, 32'd5);
        wreg(2, 0, 32'h1);
        peek(ad(2, 2), v);
        vecs++;
        if (v !== 32'd10) begin
            miss++;
            $display("[TB] FAIL stop_enable_count: got %0d expected 10", v);
        end
        idle(1);
        peek(ad(2, 2), v);
        vecs++;
        if (v !== 32'd0) begin
            miss++;
            $display("[TB] FAIL stop_below_wrap: got %0d expected 0", v);
        end
        peek(ad(2, 3), v);
        vecs++;
        if (v !== 32'd1) begin
            miss++;
            $display("[TB] FAIL stop_below_pending: got %0d expected 1", v);
        end
        wreg(0, 1, 32'hFFFF_FFFF);
        cycle(1'b1, 4'b0001, ad(0, 1), 32'h0000_00AA);
        peek(ad(0, 1), v);
        vecs++;
        if (v !== 32'hFFFF_FFAA) begin
            miss++;
            $display("[TB] FAIL byte_lane0: got %h expected ffffffaa", v);
        end
        cycle(1'b1, 4'b0100, ad(0, 1), 32'h1234_5678);
        cycle(1'b1, 4'b0000, ad(0, 1), 32'h0);
        peek(ad(0, 1), v);
        vecs++;
        if (v !== 32'hFF34_FFAA) begin
            miss++;
            $display("[TB] FAIL byte_lane2: got %h expected ff34ffaa", v);
        end
    endtask

    task automatic test_irq_mask();
        logic [31:0] v;
        quiesce();
        wreg(0, 1, 32'd2);
        wreg(1, 1, 32'd2);
        wreg(0, 0, 32'h9);
        wreg(1, 0, 32'hD);
        for (int k = 1; k <= 12; k++) begin
            idle(1);
            if (k == 2 || k == 3) begin
                vecs++;
                if (interrupt !== (k == 3)) begin
                    miss++;
                    $display("[TB] FAIL irq_ch1_only k%0d: got %b expected %b", k, interrupt, k == 3);
                end
            end
            vecs++;
            if (interrupt !== mdlIrq()) begin
                miss++;
                $display("[TB] FAIL irq_model k%0d: got %b expected %b", k, interrupt, mdlIrq());
            end
        end
        cycle(1'b1, 4'hF, ad(3, 1), 32'd7);
        for (int r = 0; r < 8; r++) begin
            peek(ad(3, r), v);
            vecs++;
            if (v !== 32'd0) begin
                miss++;
                $display("[TB] FAIL oob_read r%0d: got %h expected 0", r, v);
            end
        end
        for (int r = 5; r < 8; r++) begin
            peek(ad(0, r), v);
            vecs++;
            if (v !== 32'd0) begin
                miss++;
                $display("[TB] FAIL reserved_read r%0d: got %h expected 0", r, v);
            end
        end
        for (int c = 0; c < CH; c++) begin
            peek(ad(c, 1), v);
            vecs++;
            if (v !== mdlRead(ad(c, 1))) begin
                miss++;
                $display("[TB] FAIL oob_write ch%0d: got %h expected %h", c, v, mdlRead(ad(c, 1)));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v, d;
        logic [3:0] be;
        logic [AW-1:0] a;
        int c, r;
        quiesce();
        repeat (400) begin
            c  = $urandom_range(0, CH);
            r  = $urandom_range(0, 4);
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (r)
                0:       d = $urandom & 32'h0000_030F;
                1:       d = $urandom_range(0, 12);
                2:       d = $urandom_range(0, 15);
                4:       d = $urandom_range(0, 14);
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) cycle(1'b1, be, ad(c, r), d);
            else                           idle(1);
            a = AW'($urandom_range(0, (1 << AW) - 1));
            peek(a, v);
            vecs++;
            if (v !== mdlRead(a)) begin
                miss++;
                $display("[TB] FAIL random_read addr %0d: got %h expected %h", a, v, mdlRead(a));
            end
            vecs++;
            if (interrupt !== mdlIrq()) begin
                miss++;
                $display("[TB] FAIL random_irq: got %b expected %b", interrupt, mdlIrq());
            end
`ifdef TIMER_PWM_EN
            vecs++;
            if (pwm_out !== mdlPwm()) begin
                miss++;
                $display("[TB] FAIL random_pwm: got %b expected %b", pwm_out, mdlPwm());
            end
`endif
        end
    endtask

`ifdef TIMER_PWM_EN
    task automatic test_pwm();
        int highs;
        quiesce();
        wreg(0, 4, 32'd3);
        wreg(0, 1, 32'd9);
        wreg(1, 4, 32'd0);
        wreg(1, 1, 32'd4);
        wreg(2, 4, 32'd20);
        wreg(2, 1, 32'd4);
        wreg(1, 0, 32'h9);
        wreg(2, 0, 32'h9);
        wreg(0, 0, 32'h9);
        highs = 0;
        for (int k = 1; k <= 20; k++) begin
            idle(1);
            highs += int'(pwm_out[0]);
            vecs++;
            if (pwm_out !== mdlPwm()) begin
                miss++;
                $display("[TB] FAIL pwm_model k%0d: got %b expected %b", k, pwm_out, mdlPwm());
            end
            vecs++;
            if (pwm_out[2:1] !== 2'b10) begin
                miss++;
                $display("[TB] FAIL pwm_extremes k%0d: got %b expected 10", k, pwm_out[2:1]);
            end
        end
        vecs++;
        if (highs != 6) begin
            miss++;
            $display("[TB] FAIL pwm_duty_count: got %0d expected 6", highs);
        end
    endtask
`endif

    task automatic test_reset_midrun();
        logic [31:0] v;
        quiesce();
        wreg(1, 1, 32'd2);
        wreg(1, 0, 32'hD);
        idle(5);
        vecs++;
        if (interrupt !== 1'b1) begin
            miss++;
            $display("[TB] FAIL midrun_pre_irq: got %b expected 1", interrupt);
        end
        @(negedge clk);
        #2;
        resetq = 1'b0;
        mdlReset();
        #1;
        vecs++;
        if (interrupt !== 1'b0) begin
            miss++;
            $display("[TB] FAIL midrun_irq: got %b expected 0", interrupt);
        end
`ifdef TIMER_PWM_EN
        vecs++;
        if (pwm_out !== '0) begin
            miss++;
            $display("[TB] FAIL midrun_pwm: got %b expected 0", pwm_out);
        end
`endif
        peek(ad(1, 0), v);
        vecs++;
        if (v !== 32'd0) begin
            miss++;
            $display("[TB] FAIL midrun_ctrl: got %h expected 0", v);
        end
        peek(ad(1, 3), v);
        vecs++;
        if (v !== 32'd0) begin
            miss++;
            $display("[TB] FAIL midrun_pending: got %h expected 0", v);
        end
        releaseReset();
        peek(ad(1, 1), v);
        vecs++;
        if (v !== 32'hFFFF_FFFF) begin
            miss++;
            $display("[TB] FAIL midrun_stop: got %h expected ffffffff", v);
        end
    endtask

    initial begin
        $display("[TB] multi_timer bench start");
        test_reset();
        test_periodic();
        test_oneshot();
        test_w1c_race();
        test_stop_below();
        test_irq_mask();
`ifdef TIMER_PWM_EN
        test_pwm();
`endif
        test_random();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
